lap_stopwatch: RTL and testbench
================================

Name: lap_stopwatch

Overview:
- Parametrised successor to the single-channel stopwatch, with a configurable-depth lap memory and lap-delta readout.
- Keeps one BCD mm:ss.cc counter, advanced by a single-cycle 100 Hz enable in the sys_clk domain; there is no second clock.
- Registers the display word for the digit driver; sits under the mode mux beside the clock/alarm blocks.

Parameters:
- LAP_DEPTH, 8: number of lap entries stored (2..32).
- LAP_AW, $clog2(LAP_DEPTH): lap index width.
- MAX_MIN, 59: highest minute value before wrap (BCD, ≤99).

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mode_en  in  1  key pulses honoured only when high; pulses are masked in the same cycle it is low.
- tick_100hz  in  1  one-cycle count enable, 100 Hz.
- start_stop_pulse  in  1  one-cycle, debounced.
- clr_pulse  in  1  one-cycle, debounced.
- lap_pulse  in  1  one-cycle, debounced.
- read_pulse  in  1  one-cycle, debounced.
- delta_sel  in  1  in REVIEW: 0 shows absolute split, 1 shows split minus previous split.
- disp_bcd  out  24  {m1,m0,s1,s0,c1,c0} BCD, registered.
- running  out  1  high in RUN.
- review  out  1  high in REVIEW.
- full  out  1  lap_count == LAP_DEPTH.
- lap_count  out  LAP_AW+1  stored entries.
- lap_num  out  LAP_AW+1  1-based entry shown in REVIEW, 0 otherwise.
- wrap_pulse  out  1  one cycle when the counter wraps MAX_MIN:59.99 → 00:00.00.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 00:00.00, lap memory count 0. Memory contents are don't-care.
- Event priority per cycle: clr > start_stop > lap > read. Lower-priority pulses in the same cycle are dropped.
- States:
  - IDLE: start_stop → RUN.
  - RUN: start_stop → PAUSE; lap → store.
  - PAUSE: start_stop → RUN; read with lap_count>0 → REVIEW, showing entry 1.
  - REVIEW: read → next entry, wrapping from lap_count back to 1; start_stop → PAUSE, with no resume.
  - clr from any state → IDLE, counter zero, lap_count 0.
- Counting:
  - Counter advances on tick_100hz only while the registered state is RUN.
  - A tick in the same cycle as start from IDLE/PAUSE is not counted.
  - A tick in the same cycle as pause is counted.
- BCD carry chain: c 99→00 carries into s; s 59→00 carries into m; m MAX_MIN→00 wraps and asserts wrap_pulse. The count keeps running after a wrap.
- Lap store:
  - The value written is the counter value after any same-cycle tick.
  - Writes to entry lap_count; lap_count increments.
  - When full, the lap is ignored; full stays high and entries are unchanged.
- Delta: entry k minus entry k-1 in BCD, with entry 0 reference = 00:00.00.
  - Entries never decrease except across a wrap. If entry k < entry k-1, the delta borrows modulo (MAX_MIN+1) minutes.
- disp_bcd:
  - Counter value in IDLE/RUN/PAUSE; selected entry or delta in REVIEW.
  - Updated one cycle after its source changes.
- delta_sel outside REVIEW: no effect.
- Reset asserted mid-RUN: immediate return to reset values; no partial lap write.

Optional Feature:
- LAP_STOPWATCH_COUNTDOWN_EN defined:
  - Adds inputs cd_mode (1) and preset_bcd (24), and output expire_pulse (1).
  - With cd_mode=1, start from IDLE loads preset_bcd and the counter decrements per tick.
  - Reaching 00:00.00 asserts expire_pulse for one cycle and forces PAUSE.
  - Start at zero is ignored.
  - Lap behaviour is unchanged; delta = previous − current.
- Undefined: up-count only; ports absent.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE, REVIEW};
  - TIME_W=24;
  - ZERO_TIME;
  - BCD digit-limit constants;
  - a BCD-subtract function for the delta.
- Sub-module bcd_time_counter: up/down mm:ss.cc counter with load, clear, enable, wrap/zero flags.
- FSM and lap RAM stay in the top.

Test Plan:
- Start, 150 ticks, stop → disp_bcd=24'h000150, running=0; 3 further ticks → unchanged.
- Run to 59:59.99, 1 tick → disp_bcd=0, wrap_pulse one cycle, running=1.
- Laps at 00:01.00, 00:03.50, 00:04.00; stop; read ×4 with delta_sel=1:
  - lap_num 1,2,3,1;
  - disp 000100, 000250, 000050, 000100.
- LAP_DEPTH=8, 9 laps → full=1, lap_count=8; 9th lap not stored.
- clr and lap in the same cycle while RUN → IDLE, lap_count=0, disp_bcd=0.
- COUNTDOWN_EN, preset 24'h000005, start, 5 ticks → disp 0, expire_pulse once, state PAUSE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and helpers for the stopwatch family.
//   - sw_state_e    : top-level FSM state encoding
//   - TIME_W        : width of a packed {m1,m0,s1,s0,c1,c0} BCD time word
//   - ZERO_TIME     : 00:00.00
//   - digit limits  : highest value of a decimal digit / tens-of-seconds digit
//   - bcd_time_sub  : a - b on BCD time words, minutes taken modulo (max_min+1)
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    REVIEW = 2'd3
  } sw_state_e;

  localparam int                TIME_W       = 24;
  localparam logic [TIME_W-1:0] ZERO_TIME    = '0;
  localparam logic [3:0]        DIGIT_MAX    = 4'd9;
  localparam logic [3:0]        SEC_TENS_MAX = 4'd5;

  // Digit-serial borrow subtraction. Centiseconds and seconds borrow in their
  // natural radix; minutes are treated as one binary quantity so that a
  // negative result folds back modulo (max_min+1), which is what a split taken
  // across a counter wrap needs.
  function automatic logic [TIME_W-1:0] bcd_time_sub(input logic [TIME_W-1:0] a,
                                                     input logic [TIME_W-1:0] b,
                                                     input int max_min);
    int c0, c1, s0, s1, m, bor;
    c0  = int'(a[3:0]) - int'(b[3:0]);
    bor = 0;
    if (c0 < 0) begin c0 = c0 + 10; bor = 1; end
    c1  = int'(a[7:4]) - int'(b[7:4]) - bor;
    bor = 0;
    if (c1 < 0) begin c1 = c1 + 10; bor = 1; end
    s0  = int'(a[11:8]) - int'(b[11:8]) - bor;
    bor = 0;
    if (s0 < 0) begin s0 = s0 + 10; bor = 1; end
    s1  = int'(a[15:12]) - int'(b[15:12]) - bor;
    bor = 0;
    if (s1 < 0) begin s1 = s1 + 6; bor = 1; end
    m = (int'(a[23:20]) * 10 + int'(a[19:16])) -
        (int'(b[23:20]) * 10 + int'(b[19:16])) - bor;
    if (m < 0) m = m + max_min + 1;
    return {4'(m / 10), 4'(m % 10), 4'(s1), 4'(s0), 4'(c1), 4'(c0)};
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: up/down mm:ss.cc BCD counter.
//   sys_clk, rst_n : clock, async active-low reset (value -> 00:00.00)
//   clr            : synchronous clear (highest priority)
//   load/load_val  : synchronous load
//   en             : advance one centisecond this cycle
//   down           : 1 = decrement, 0 = increment
//   value          : registered count
//   next_value     : value after this edge (lets callers capture a same-cycle tick)
//   wrap           : this edge wraps MAX_MIN:59.99 -> 00:00.00 (up only)
//   next_zero      : next_value is 00:00.00
// MAX_MIN is a plain decimal minute count (59 -> wraps after 59:59.99).
module bcd_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              en,
  input  logic              down,
  output logic [TIME_W-1:0] value,
  output logic [TIME_W-1:0] next_value,
  output logic              wrap,
  output logic              next_zero
);

  localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

  logic [TIME_W-1:0] value_q;
  logic [3:0] m1, m0, s1, s0, c1, c0;
  logic [3:0] nm1, nm0, ns1, ns0, nc1, nc0;
  logic       step_wrap;

  assign {m1, m0, s1, s0, c1, c0} = value_q;

  always_comb begin
    {nm1, nm0, ns1, ns0, nc1, nc0} = value_q;
    step_wrap = 1'b0;
    if (en) begin
      if (!down) begin
        if (c0 != DIGIT_MAX) nc0 = c0 + 4'd1;
        else begin
          nc0 = 4'd0;
          if (c1 != DIGIT_MAX) nc1 = c1 + 4'd1;
          else begin
            nc1 = 4'd0;
            if (s0 != DIGIT_MAX) ns0 = s0 + 4'd1;
            else begin
              ns0 = 4'd0;
              if (s1 != SEC_TENS_MAX) ns1 = s1 + 4'd1;
              else begin
                ns1 = 4'd0;
                if (m1 == MAX_M1 && m0 == MAX_M0) begin
                  nm1 = 4'd0;
                  nm0 = 4'd0;
                  step_wrap = 1'b1;
                end else if (m0 != DIGIT_MAX) nm0 = m0 + 4'd1;
                else begin
                  nm0 = 4'd0;
                  nm1 = m1 + 4'd1;
                end
              end
            end
          end
        end
      end else begin
        if (c0 != 4'd0) nc0 = c0 - 4'd1;
        else begin
          nc0 = DIGIT_MAX;
          if (c1 != 4'd0) nc1 = c1 - 4'd1;
          else begin
            nc1 = DIGIT_MAX;
            if (s0 != 4'd0) ns0 = s0 - 4'd1;
            else begin
              ns0 = DIGIT_MAX;
              if (s1 != 4'd0) ns1 = s1 - 4'd1;
              else begin
                ns1 = SEC_TENS_MAX;
                if (m1 == 4'd0 && m0 == 4'd0) begin
                  nm1 = MAX_M1;
                  nm0 = MAX_M0;
                end else if (m0 != 4'd0) nm0 = m0 - 4'd1;
                else begin
                  nm0 = DIGIT_MAX;
                  nm1 = m1 - 4'd1;
                end
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    next_value = {nm1, nm0, ns1, ns0, nc1, nc0};
    if (clr)       next_value = ZERO_TIME;
    else if (load) next_value = load_val;
  end

  assign wrap      = step_wrap && !clr && !load;
  assign next_zero = (next_value == ZERO_TIME);
  assign value     = value_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) value_q <= ZERO_TIME;
    else        value_q <= next_value;
  end

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: mm:ss.cc stopwatch with lap memory and lap-delta review.
//   sys_clk, rst_n     : clock, async active-low reset
//   mode_en            : key pulses are honoured only while high
//   tick_100hz         : one-cycle count enable
//   start_stop_pulse, clr_pulse, lap_pulse, read_pulse : debounced key pulses
//   delta_sel          : in REVIEW, 0 = absolute split, 1 = split delta
//   disp_bcd           : registered {m1,m0,s1,s0,c1,c0}
//   running / review   : state is RUN / REVIEW
//   full, lap_count    : lap memory occupancy
//   lap_num            : 1-based entry shown in REVIEW, else 0
//   wrap_pulse         : one cycle after the count wraps to 00:00.00
// Optional build macro LAP_STOPWATCH_COUNTDOWN_EN adds cd_mode, preset_bcd and
// expire_pulse: a countdown start from IDLE loads preset_bcd and counts down,
// expiring into PAUSE at 00:00.00.
// Handshake: all key inputs are single-cycle pulses with no back-pressure; a
// pulse is either acted on in the cycle it is high or dropped.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH = 8,
  parameter int LAP_AW    = $clog2(LAP_DEPTH),
  parameter int MAX_MIN   = 59
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              mode_en,
  input  logic              tick_100hz,
  input  logic              start_stop_pulse,
  input  logic              clr_pulse,
  input  logic              lap_pulse,
  input  logic              read_pulse,
  input  logic              delta_sel,
  output logic [TIME_W-1:0] disp_bcd,
  output logic              running,
  output logic              review,
  output logic              full,
  output logic [LAP_AW:0]   lap_count,
  output logic [LAP_AW:0]   lap_num,
  output logic              wrap_pulse
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
  ,
  input  logic              cd_mode,
  input  logic [TIME_W-1:0] preset_bcd,
  output logic              expire_pulse
`endif
);

  localparam logic [LAP_AW:0] DEPTH_V = (LAP_AW + 1)'(LAP_DEPTH);
  localparam logic [LAP_AW:0] ONE_V   = (LAP_AW + 1)'(1);

  sw_state_e         state_q, state_d;
  logic [LAP_AW:0]   lap_count_q, rev_idx_q, rev_idx_d;
  logic              down_q, down_d;
  logic [TIME_W-1:0] ref_q, ref_d;
  logic [TIME_W-1:0] disp_q, disp_d;
  logic              wrap_q;
  logic              lap_we, cnt_load, cnt_en, full_w;
  logic              ev_clr, ev_ss, ev_lap, ev_read;
  logic              cd_req, cd_expire;
  logic [TIME_W-1:0] cd_preset;
  logic [TIME_W-1:0] cnt_value, cnt_next;
  logic              cnt_wrap, cnt_next_zero;
  logic [TIME_W-1:0] lap_mem [0:LAP_DEPTH-1];
  logic [LAP_AW-1:0] wr_idx, rd_idx, prev_idx;
  logic [TIME_W-1:0] entry_v, prev_v, delta_v;

  // Masking and priority: clr > start_stop > lap > read.
  assign ev_clr  = mode_en && clr_pulse;
  assign ev_ss   = mode_en && start_stop_pulse && !clr_pulse;
  assign ev_lap  = mode_en && lap_pulse && !clr_pulse && !start_stop_pulse;
  assign ev_read = mode_en && read_pulse && !clr_pulse && !start_stop_pulse && !lap_pulse;

  assign full_w = (lap_count_q == DEPTH_V);
  // A tick only counts while the registered state is RUN, so a start tick is
  // lost and a pause tick is kept.
  assign cnt_en = tick_100hz && (state_q == RUN) && !ev_clr;

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
  logic expire_q;
  assign cd_req    = cd_mode;
  assign cd_preset = preset_bcd;
  assign cd_expire = cnt_en && down_q && cnt_next_zero;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) expire_q <= 1'b0;
    else        expire_q <= cd_expire;
  end
  assign expire_pulse = expire_q;
`else
  assign cd_req    = 1'b0;
  assign cd_preset = ZERO_TIME;
  assign cd_expire = 1'b0;
`endif

  bcd_time_counter #(.MAX_MIN(MAX_MIN)) u_counter (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .clr        (ev_clr),
    .load       (cnt_load),
    .load_val   (cd_preset),
    .en         (cnt_en),
    .down       (down_q),
    .value      (cnt_value),
    .next_value (cnt_next),
    .wrap       (cnt_wrap),
    .next_zero  (cnt_next_zero)
  );

  always_comb begin
    state_d   = state_q;
    rev_idx_d = rev_idx_q;
    down_d    = down_q;
    ref_d     = ref_q;
    lap_we    = 1'b0;
    cnt_load  = 1'b0;
    if (ev_clr) begin
      state_d   = IDLE;
      rev_idx_d = '0;
      down_d    = 1'b0;
      ref_d     = ZERO_TIME;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ev_ss) begin
            if (cd_req) begin
              // A countdown from zero has nothing to count.
              if (cd_preset != ZERO_TIME) begin
                cnt_load = 1'b1;
                down_d   = 1'b1;
                ref_d    = cd_preset;
                state_d  = RUN;
              end
            end else begin
              down_d  = 1'b0;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (ev_ss || cd_expire) state_d = PAUSE;
          if (ev_lap && !full_w) lap_we = 1'b1;
        end
        PAUSE: begin
          if (ev_ss) begin
            if (!(down_q && cnt_value == ZERO_TIME)) state_d = RUN;
          end else if (ev_read && lap_count_q != '0) begin
            state_d   = REVIEW;
            rev_idx_d = ONE_V;
          end
        end
        REVIEW: begin
          if (ev_ss) begin
            state_d   = PAUSE;
            rev_idx_d = '0;
          end else if (ev_read) begin
            rev_idx_d = (rev_idx_q == lap_count_q) ? ONE_V : rev_idx_q + ONE_V;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign wr_idx   = lap_count_q[LAP_AW-1:0];
  assign rd_idx   = LAP_AW'(rev_idx_q - ONE_V);
  assign prev_idx = LAP_AW'(rev_idx_q - (ONE_V + ONE_V));

  // Entry 1 is referenced to the run's start value (zero, or the preset).
  always_comb begin
    entry_v = lap_mem[rd_idx];
    prev_v  = (rev_idx_q == ONE_V) ? ref_q : lap_mem[prev_idx];
    delta_v = down_q ? bcd_time_sub(prev_v, entry_v, MAX_MIN)
                     : bcd_time_sub(entry_v, prev_v, MAX_MIN);
    disp_d  = cnt_value;
    if (state_q == REVIEW) disp_d = delta_sel ? delta_v : entry_v;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lap_count_q <= '0;
      rev_idx_q   <= '0;
      down_q      <= 1'b0;
      ref_q       <= ZERO_TIME;
      disp_q      <= ZERO_TIME;
      wrap_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rev_idx_q <= rev_idx_d;
      down_q    <= down_d;
      ref_q     <= ref_d;
      disp_q    <= disp_d;
      wrap_q    <= cnt_wrap;
      if (ev_clr)      lap_count_q <= '0;
      else if (lap_we) lap_count_q <= lap_count_q + ONE_V;
    end
  end

  // Lap RAM carries no reset; entries above lap_count are never displayed.
  always_ff @(posedge sys_clk) begin
    if (lap_we) lap_mem[wr_idx] <= cnt_next;
  end

  assign disp_bcd   = disp_q;
  assign running    = (state_q == RUN);
  assign review     = (state_q == REVIEW);
  assign full       = full_w;
  assign lap_count  = lap_count_q;
  assign lap_num    = rev_idx_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: directed bench for lap_stopwatch. A second instance with
// MAX_MIN=1 shares all stimulus so the minute wrap is reachable quickly.
module tb_lap_stopwatch;

  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode_en = 1'b1;
  logic tick_100hz = 1'b0;
  logic start_stop_pulse = 1'b0;
  logic clr_pulse = 1'b0;
  logic lap_pulse = 1'b0;
  logic read_pulse = 1'b0;
  logic delta_sel = 1'b0;

  logic [23:0] disp_bcd, disp_bcd_w;
  logic        running, running_w, review, review_w, full, full_w;
  logic [3:0]  lap_count, lap_count_w, lap_num, lap_num_w;
  logic        wrap_pulse, wrap_pulse_w;
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
  logic        cd_mode = 1'b0;
  logic [23:0] preset_bcd = '0;
  logic        expire_pulse, expire_pulse_w;
`endif

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  logic [3:0]  exp_num_q[$];

  always #5 sys_clk = ~sys_clk;

  lap_stopwatch dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .mode_en(mode_en), .tick_100hz(tick_100hz),
    .start_stop_pulse(start_stop_pulse), .clr_pulse(clr_pulse), .lap_pulse(lap_pulse),
    .read_pulse(read_pulse), .delta_sel(delta_sel), .disp_bcd(disp_bcd),
    .running(running), .review(review), .full(full), .lap_count(lap_count),
    .lap_num(lap_num), .wrap_pulse(wrap_pulse)
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
    , .cd_mode(cd_mode), .preset_bcd(preset_bcd), .expire_pulse(expire_pulse)
`endif
  );

  lap_stopwatch #(.MAX_MIN(1)) dut_w (
    .sys_clk(sys_clk), .rst_n(rst_n), .mode_en(mode_en), .tick_100hz(tick_100hz),
    .start_stop_pulse(start_stop_pulse), .clr_pulse(clr_pulse), .lap_pulse(lap_pulse),
    .read_pulse(read_pulse), .delta_sel(delta_sel), .disp_bcd(disp_bcd_w),
    .running(running_w), .review(review_w), .full(full_w), .lap_count(lap_count_w),
    .lap_num(lap_num_w), .wrap_pulse(wrap_pulse_w)
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
    , .cd_mode(cd_mode), .preset_bcd(preset_bcd), .expire_pulse(expire_pulse_w)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the falling edge.
  task automatic step(input logic ss, input logic clr, input logic lap,
                      input logic rd, input logic tk);
    start_stop_pulse = ss;
    clr_pulse        = clr;
    lap_pulse        = lap;
    read_pulse       = rd;
    tick_100hz       = tk;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start_stop_pulse = 1'b0;
    clr_pulse        = 1'b0;
    lap_pulse        = 1'b0;
    read_pulse       = 1'b0;
    tick_100hz       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) step(0, 0, 0, 0, 1);
  endtask

  initial begin
    // clock/reset
    @(negedge sys_clk);
    @(negedge sys_clk);
    check_eq("rst_disp", disp_bcd, 24'h0);
    check_eq("rst_running", running, 0);
    check_eq("rst_review", review, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_lap_count", lap_count, 0);
    check_eq("rst_lap_num", lap_num, 0);
    check_eq("rst_wrap", wrap_pulse, 0);
    rst_n = 1'b1;
    idle(1);

    // mode_en low masks key pulses
    mode_en = 1'b0;
    step(1, 0, 0, 0, 0);
    check_eq("masked_start", running, 0);
    mode_en = 1'b1;

    // start, 150 ticks, stop
    step(1, 0, 0, 0, 0);
    check_eq("start_running", running, 1);
    ticks(150);
    step(1, 0, 0, 0, 0);
    check_eq("stop_running", running, 0);
    idle(1);
    check_eq("disp_150", disp_bcd, 24'h000150);
    ticks(3);
    idle(1);
    check_eq("paused_hold", disp_bcd, 24'h000150);
    step(0, 0, 0, 1, 0);
    check_eq("read_no_laps", review, 0);

    // tick during pause is counted
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    idle(1);
    check_eq("pause_tick", disp_bcd, 24'h000151);

    // tick during start is not counted
    step(0, 1, 0, 0, 0);
    idle(1);
    check_eq("clr_disp", disp_bcd, 24'h0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    idle(1);
    check_eq("start_tick", disp_bcd, 24'h0);

    // carries and wrap (dut_w wraps after 01:59.99)
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    ticks(6000);
    idle(1);
    check_eq("min_carry", disp_bcd, 24'h010000);
    ticks(5999);
    idle(1);
    check_eq("pre_wrap_disp", disp_bcd_w, 24'h015999);
    check_eq("pre_wrap_pulse", wrap_pulse_w, 0);
    ticks(1);
    check_eq("wrap_pulse", wrap_pulse_w, 1);
    check_eq("wrap_running", running_w, 1);
    check_eq("no_wrap_main", wrap_pulse, 0);
    idle(1);
    check_eq("wrap_pulse_end", wrap_pulse_w, 0);
    check_eq("wrap_disp", disp_bcd_w, 24'h0);
    check_eq("main_2min", disp_bcd, 24'h020000);
    ticks(1);
    idle(1);
    check_eq("after_wrap", disp_bcd_w, 24'h000001);

    // laps at 00:01.00, 00:03.50, 00:04.00 then review deltas
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    ticks(99);
    step(0, 0, 1, 0, 1);
    check_eq("lap1_count", lap_count, 1);
    ticks(249);
    step(0, 0, 1, 0, 1);
    ticks(49);
    step(0, 0, 1, 0, 1);
    check_eq("lap3_count", lap_count, 3);
    step(1, 0, 0, 0, 0);
    delta_sel = 1'b1;
    exp_q = {24'h000100, 24'h000250, 24'h000050, 24'h000100};
    exp_num_q = {4'd1, 4'd2, 4'd3, 4'd1};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      idle(1);
      check_eq("review_flag", review, 1);
      check_eq("review_num", lap_num, exp_num_q.pop_front());
      check_eq("review_delta", disp_bcd, exp_q.pop_front());
    end
    delta_sel = 1'b0;
    step(0, 0, 0, 1, 0);
    idle(1);
    check_eq("abs_num", lap_num, 2);
    check_eq("abs_disp", disp_bcd, 24'h000350);
    step(1, 0, 0, 0, 0);
    check_eq("leave_review", review, 0);
    check_eq("leave_num", lap_num, 0);
    check_eq("no_resume", running, 0);
    idle(1);
    check_eq("leave_disp", disp_bcd, 24'h000400);

    // fill the lap memory
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 1, 0, 1);
      if (i == 7) check_eq("not_full", full, 0);
    end
    check_eq("full_flag", full, 1);
    check_eq("full_count", lap_count, 8);
    step(1, 0, 0, 0, 0);
    repeat (8) step(0, 0, 0, 1, 0);
    idle(1);
    check_eq("last_num", lap_num, 8);
    check_eq("last_entry", disp_bcd, 24'h000008);
    step(0, 0, 0, 1, 0);
    idle(1);
    check_eq("wrap_num", lap_num, 1);
    check_eq("wrap_entry", disp_bcd, 24'h000001);

    // clr beats lap in the same cycle
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    ticks(5);
    step(0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 0);
    check_eq("clrlap_running", running, 0);
    check_eq("clrlap_count", lap_count, 0);
    idle(1);
    check_eq("clrlap_disp", disp_bcd, 24'h0);

    // reset mid-run
    step(1, 0, 0, 0, 0);
    ticks(10);
    step(0, 0, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_running", running, 0);
    check_eq("async_rst_count", lap_count, 0);
    check_eq("async_rst_disp", disp_bcd, 24'h0);
    rst_n = 1'b1;
    idle(1);

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
    cd_mode = 1'b1;
    preset_bcd = 24'h0;
    step(1, 0, 0, 0, 0);
    check_eq("cd_zero_start", running, 0);
    preset_bcd = 24'h000005;
    step(1, 0, 0, 0, 0);
    check_eq("cd_running", running, 1);
    idle(1);
    check_eq("cd_loaded", disp_bcd, 24'h000005);
    ticks(4);
    check_eq("cd_not_expired", expire_pulse, 0);
    ticks(1);
    check_eq("cd_expire", expire_pulse, 1);
    check_eq("cd_paused", running, 0);
    idle(1);
    check_eq("cd_expire_end", expire_pulse, 0);
    check_eq("cd_disp", disp_bcd, 24'h0);
    step(1, 0, 0, 0, 0);
    check_eq("cd_restart_zero", running, 0);
    cd_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
